// File: rtl/conv2x2_window_gen_if.sv
// ============================================================================
// Module      : conv2x2_window_gen_if
// Description : Handshake bundle for the 2x2 window extractor. It carries
//               the pixel input stream (valid/ready/data/sof) and the
//               window output stream (valid/ready/data/last).
//               master : upstream pixel source / downstream window sink
//               slave  : the window generator itself
// Ports       : pix_valid, pix_ready, pix_data[PIX_W], pix_sof,
//               win_valid, win_ready, win_data[4*PIX_W], win_last
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv2x2_window_gen_if #(
    parameter int PIX_W = 8
) ();
    logic                   pix_valid;
    logic                   pix_ready;
    logic [PIX_W-1:0]       pix_data;
    logic                   pix_sof;
    logic                   win_valid;
    logic                   win_ready;
    logic [4*PIX_W-1:0]     win_data;
    logic                   win_last;

    modport master (
        output pix_valid, pix_data, pix_sof, win_ready,
        input  pix_ready, win_valid, win_data, win_last
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, win_ready,
        output pix_ready, win_valid, win_data, win_last
    );
endinterface

`default_nettype wire

// File: rtl/conv2x2_window_gen.sv
// ============================================================================
// Module      : conv2x2_window_gen
// Description : Streaming 2x2 window extractor, stride 1. Accepts one
//               raster-order pixel per handshake, keeps the previous row in a
//               line buffer and emits the 2x2 neighbourhood ending at each
//               pixel as a packed word through a single output register.
//               Lane order: lane0=(r-1,c-1) lane1=(r-1,c) lane2=(r,c-1)
//               lane3=(r,c), lane k at win_data[k*PIX_W +: PIX_W].
// Ports       : clk, rst (async, active-high)
//               bus (slave): pix_valid/pix_ready/pix_data/pix_sof in,
//                            win_valid/win_ready/win_data/win_last out
// Options     : CONV_WIN_ZEROPAD_EN - when defined, every pixel yields a
//               window and lanes outside the image read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2x2_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    conv2x2_window_gen_if.slave bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] c_col_max = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_max = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_col_one = CW'(1);
    localparam logic [RW-1:0] c_row_one = RW'(1);

    // Registered state
    logic [CW-1:0]          col_q,       col_d;
    logic [RW-1:0]          row_q,       row_d;
    logic [PIX_W-1:0]       left_q,      left_d;
    logic [PIX_W-1:0]       upleft_q,    upleft_d;
    logic                   win_valid_q, win_valid_d;
    logic [4*PIX_W-1:0]     win_data_q,  win_data_d;
    logic                   win_last_q,  win_last_d;

    // Line buffer holding the previous row; contents are don't-care until
    // written in the current frame, the eligibility rule hides stale entries.
    logic [PIX_W-1:0]       line_mem [IMG_W];

    logic                   w_pix_ready;
    logic                   w_accept;
    logic [CW-1:0]          w_col;
    logic [RW-1:0]          w_row;
    logic [PIX_W-1:0]       w_above;
    logic                   w_make_win;
    logic [PIX_W-1:0]       w_lane0;
    logic [PIX_W-1:0]       w_lane1;
    logic [PIX_W-1:0]       w_lane2;

    // Single output register, no skid: take a pixel only when the output
    // register is empty or being drained this cycle.
    assign w_pix_ready   = !win_valid_q || bus.win_ready;
    assign bus.pix_ready = w_pix_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
    assign bus.win_last  = win_last_q;

    always_comb begin
        w_accept = bus.pix_valid && w_pix_ready;

        // sof pins the accepted pixel to (0,0) regardless of the counters
        w_col    = bus.pix_sof ? '0 : col_q;
        w_row    = bus.pix_sof ? '0 : row_q;
        w_above  = line_mem[w_col];

`ifdef CONV_WIN_ZEROPAD_EN
        w_make_win = 1'b1;
        w_lane0    = ((w_row != '0) && (w_col != '0)) ? upleft_q : '0;
        w_lane1    = (w_row != '0) ? w_above : '0;
        w_lane2    = (w_col != '0) ? left_q  : '0;
`else
        w_make_win = (w_row != '0) && (w_col != '0);
        w_lane0    = upleft_q;
        w_lane1    = w_above;
        w_lane2    = left_q;
`endif
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        left_d      = left_q;
        upleft_d    = upleft_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_last_d  = win_last_q;

        if (w_accept) begin
            // Upper-left of the next window is the pixel above this one.
            left_d   = bus.pix_data;
            upleft_d = w_above;

            if (w_col == c_col_max) begin
                col_d = '0;
                row_d = (w_row == c_row_max) ? '0 : (w_row + c_row_one);
            end else begin
                col_d = w_col + c_col_one;
                row_d = w_row;
            end
        end

        if (w_accept && w_make_win) begin
            win_valid_d = 1'b1;
            win_data_d  = {bus.pix_data, w_lane2, w_lane1, w_lane0};
            win_last_d  = (w_row == c_row_max) && (w_col == c_col_max);
        end else if (win_valid_q && bus.win_ready) begin
            // Window drained and nothing replaces it; data/last simply hold.
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            left_q      <= '0;
            upleft_q    <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            left_q      <= left_d;
            upleft_q    <= upleft_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_last_q  <= win_last_d;
        end
    end

    // Read-before-write: w_above samples the old entry in the same cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            line_mem[w_col] <= bus.pix_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv2x2_window_gen.sv
// ============================================================================
// Module      : tb_conv2x2_window_gen
// Description : Self-checking bench for conv2x2_window_gen (IMG_W=4,
//               IMG_H=3). Fixed vector table for the 1..12 frame, directed
//               backpressure / multi-frame / sof / reset sequences, and a
//               randomized run against an image-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv2x2_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int PIX_W = 8;

`ifdef CONV_WIN_ZEROPAD_EN
    localparam int          FIRST_K      = 1;
    localparam int          EXP_WINS     = 12;
    localparam logic [31:0] FIRST_WORD   = 32'h01000000;
    localparam logic [31:0] SECOND_FIRST = 32'h15000000;
`else
    localparam int          FIRST_K      = 6;
    localparam int          EXP_WINS     = 6;
    localparam logic [31:0] FIRST_WORD   = 32'h06050201;
    localparam logic [31:0] SECOND_FIRST = 32'h1A191615;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv2x2_window_gen_if #(.PIX_W(PIX_W)) bus ();

    conv2x2_window_gen #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .PIX_W(PIX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0]  pix;
        logic        sof;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs[12];

    int total = 0;
    int bad   = 0;

    // Reference model: the frame as a 2D image plus the output register view
    logic [7:0]  img [IMG_H][IMG_W];
    int          m_row;
    int          m_col;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    int          nwin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pixel_at(input int r, input int c);
        if (r < 0 || c < 0) return 8'h00;
        return img[r][c];
    endfunction

    task automatic model_reset();
        m_row   = 0;
        m_col   = 0;
        m_valid = 1'b0;
        m_data  = 32'h0;
        m_last  = 1'b0;
    endtask

    // One clock of stimulus; model advanced and all outputs compared.
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic rdy);
        logic exp_ready;
        logic acc;
        logic produce;
        int   r;
        int   c;
        int   idx;
        bus.pix_valid = v;
        bus.pix_data  = d;
        bus.pix_sof   = s;
        bus.win_ready = rdy;
        #1;
        exp_ready = !m_valid || rdy;
        check("pix_ready", 32'(bus.pix_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clk);
        if (m_valid && rdy) nwin++;
        if (acc) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = d;
`ifdef CONV_WIN_ZEROPAD_EN
            produce = 1'b1;
`else
            produce = (r >= 1) && (c >= 1);
`endif
            if (produce) begin
                m_valid = 1'b1;
                m_data  = {d, pixel_at(r, c - 1), pixel_at(r - 1, c), pixel_at(r - 1, c - 1)};
                m_last  = (r == IMG_H - 1) && (c == IMG_W - 1);
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            idx   = (r * IMG_W + c + 1) % (IMG_W * IMG_H);
            m_row = idx / IMG_W;
            m_col = idx % IMG_W;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check("win_valid", 32'(bus.win_valid), 32'(m_valid));
        check("win_data",  bus.win_data,       m_data);
        check("win_last",  32'(bus.win_last),  32'(m_last));
    endtask

    task automatic run_table(input string tag);
        int n0;
        n0 = nwin;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, vecs[i].pix, vecs[i].sof, 1'b1);
            check($sformatf("%s_valid%0d", tag, i), 32'(bus.win_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("%s_data%0d", tag, i), bus.win_data, vecs[i].exp_data);
                check($sformatf("%s_last%0d", tag, i), 32'(bus.win_last), 32'(vecs[i].exp_last));
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check({tag, "_drained"}, 32'(bus.win_valid), 32'd0);
        check({tag, "_count"}, 32'(nwin - n0), 32'(EXP_WINS));
    endtask

    initial begin
        logic [31:0] tw [12];
        logic [11:0] tv;
        int          n0;
        logic        v;
        logic        s;
        logic        rdy;

`ifdef CONV_WIN_ZEROPAD_EN
        tv = 12'hFFF;
        tw = '{32'h01000000, 32'h02010000, 32'h03020000, 32'h04030000,
               32'h05000100, 32'h06050201, 32'h07060302, 32'h08070403,
               32'h09000500, 32'h0A090605, 32'h0B0A0706, 32'h0C0B0807};
`else
        tv = 12'b1110_1110_0000;
        tw = '{32'h0, 32'h0, 32'h0, 32'h0,
               32'h0, 32'h06050201, 32'h07060302, 32'h08070403,
               32'h0, 32'h0A090605, 32'h0B0A0706, 32'h0C0B0807};
`endif
        for (int i = 0; i < 12; i++) begin
            vecs[i] = '{8'(i + 1), (i == 0), tv[i], tw[i], (i == 11)};
        end

        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = 8'h00;
        nwin = 0;
        model_reset();

        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.pix_sof   = 1'b0;
        bus.win_ready = 1'b0;
        #12;
        check("rst_win_valid", 32'(bus.win_valid), 32'd0);
        check("rst_win_data",  bus.win_data,       32'd0);
        check("rst_win_last",  32'(bus.win_last),  32'd0);
        check("rst_pix_ready", 32'(bus.pix_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame 1..12
        run_table("tbl");

        // Backpressure for 3 cycles right after the first window
        n0 = nwin;
        for (int k = 1; k <= FIRST_K; k++) step(1'b1, 8'(k), (k == 1), 1'b1);
        check("bp_first", bus.win_data, FIRST_WORD);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'(FIRST_K + 1), 1'b0, 1'b0);
            check($sformatf("bp_ready%0d", k), 32'(bus.pix_ready), 32'd0);
            check($sformatf("bp_hold%0d", k), bus.win_data, FIRST_WORD);
        end
        for (int k = FIRST_K + 1; k <= 12; k++) step(1'b1, 8'(k), 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("bp_count", 32'(nwin - n0), 32'(EXP_WINS));

        // Two back-to-back frames
        for (int k = 0; k < 12; k++) step(1'b1, 8'(1 + k), (k == 0), 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 8'(21 + k), (k == 0), 1'b1);
            if (k == FIRST_K - 1) check("b2b_first", bus.win_data, SECOND_FIRST);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // sof reasserted on the 6th pixel of a frame
        for (int k = 1; k <= 5; k++) step(1'b1, 8'(k), (k == 1), 1'b1);
        step(1'b1, 8'h40, 1'b1, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 8'(8'h40 + k), 1'b0, 1'b1);
`ifndef CONV_WIN_ZEROPAD_EN
            if (k < 5) check($sformatf("sof_nowin%0d", k), 32'(bus.win_valid), 32'd0);
`endif
        end
`ifndef CONV_WIN_ZEROPAD_EN
        check("sof_win", bus.win_data, 32'h45444140);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset while a window is held
        for (int k = 1; k <= FIRST_K; k++) step(1'b1, 8'(k), (k == 1), 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(bus.win_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_win_valid", 32'(bus.win_valid), 32'd0);
        check("arst_win_data",  bus.win_data,       32'd0);
        check("arst_win_last",  32'(bus.win_last),  32'd0);
        model_reset();
        #3;
        rst = 1'b0;
        run_table("post_rst");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s   = (i == 0) || ($urandom_range(0, 39) == 0);
            v   = s || ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 7);
            step(v, 8'($urandom), s, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
